// File: rtl/edge_delay_pkg.sv
// Shared types and defaults for the edge-to-edge delay meter.
package edge_delay_pkg;

   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/edge_delay_meter_minmax.sv
// Running minimum/maximum tracker for one delay direction.
module minmax_track
   import edge_delay_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             upd,
   input  logic [CNT_W-1:0] value,
   output logic [CNT_W-1:0] min,
   output logic [CNT_W-1:0] max
);

   // Empty statistics: min saturated high, max at zero, so the first sample sets both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min <= '1;
         max <= '0;
      end else if (clear) begin
         min <= '1;
         max <= '0;
      end else if (upd) begin
         if (value < min) min <= value;
         if (value > max) max <= value;
      end
   end

endmodule

// File: rtl/edge_delay_meter.sv
// Measures stim-edge to resp-edge delay in clock cycles, with per-direction min/max stats.
module edge_delay_meter
   import edge_delay_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned INVERT  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stim,
   input  logic             resp,
   input  logic             clear,
   output logic             meas_valid,
   output logic             meas_rise,
   output logic [CNT_W-1:0] meas_delay,
   output logic             timeout,
   output logic             abort,
   output logic [CNT_W-1:0] rise_min,
   output logic [CNT_W-1:0] rise_max,
   output logic [CNT_W-1:0] fall_min,
   output logic [CNT_W-1:0] fall_max
);

   state_t           state, state_d;
   logic             stim_q, resp_q;
   logic             exp_q, exp_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             emit, emit_rise;
   logic [CNT_W-1:0] emit_delay;
   logic             timeout_d, abort_d;
   logic             stim_edge, exp_lvl;

   assign stim_edge = (stim != stim_q);
   assign exp_lvl   = stim ^ 1'(INVERT);

   // Next-state and pulse decode.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      exp_d      = exp_q;
      emit       = 1'b0;
      emit_rise  = 1'b0;
      emit_delay = '0;
      timeout_d  = 1'b0;
      abort_d    = 1'b0;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state)
            INIT: state_d = IDLE;
            IDLE: begin
               if (stim_edge) begin
                  if (resp == exp_lvl) begin
                     emit      = 1'b1;
                     emit_rise = exp_lvl;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     exp_d   = exp_lvl;
                     state_d = WAIT;
                  end
               end
            end
            WAIT: begin
               if (stim_edge) begin
                  abort_d = 1'b1;
                  cnt_d   = CNT_W'(1);
                  exp_d   = exp_lvl;
               end else if (resp == exp_q) begin
                  emit       = 1'b1;
                  emit_rise  = exp_q;
                  emit_delay = cnt;
                  state_d    = IDLE;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, samples, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= INIT;
         stim_q     <= 1'b0;
         resp_q     <= 1'b0;
         exp_q      <= 1'b0;
         cnt        <= '0;
         meas_valid <= 1'b0;
         meas_rise  <= 1'b0;
         meas_delay <= '0;
         timeout    <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state      <= state_d;
         stim_q     <= stim;
         resp_q     <= resp;
         exp_q      <= exp_d;
         cnt        <= cnt_d;
         meas_valid <= emit;
         timeout    <= timeout_d;
         abort      <= abort_d;
         if (emit) begin
            meas_rise  <= emit_rise;
            meas_delay <= emit_delay;
         end
      end
   end

   minmax_track #(.CNT_W(CNT_W)) u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .upd   (emit & emit_rise),
      .value (emit_delay),
      .min   (rise_min),
      .max   (rise_max)
   );

   minmax_track #(.CNT_W(CNT_W)) u_fall (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .upd   (emit & ~emit_rise),
      .value (emit_delay),
      .min   (fall_min),
      .max   (fall_max)
   );

endmodule

// File: tb/tb_edge_delay_meter.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_edge_delay_meter;

   localparam int unsigned W  = 8;
   localparam int unsigned TO = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic stim0, resp0, stim1, resp1;
   logic v0, r0, t0, a0, v1, r1, t1, a1;
   logic [W-1:0] d0, rmin0, rmax0, fmin0, fmax0;
   logic [W-1:0] d1, rmin1, rmax1, fmin1, fmax1;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         kind;   // 0 measurement, 1 timeout, 2 abort
      logic       rise;
      logic [W-1:0] delay;
      int         at;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   edge_delay_meter #(.CNT_W(W), .TIMEOUT(TO), .INVERT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .stim(stim0), .resp(resp0), .clear(clear),
      .meas_valid(v0), .meas_rise(r0), .meas_delay(d0), .timeout(t0), .abort(a0),
      .rise_min(rmin0), .rise_max(rmax0), .fall_min(fmin0), .fall_max(fmax0)
   );

   edge_delay_meter #(.CNT_W(W), .TIMEOUT(TO), .INVERT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .stim(stim1), .resp(resp1), .clear(clear),
      .meas_valid(v1), .meas_rise(r1), .meas_delay(d1), .timeout(t1), .abort(a1),
      .rise_min(rmin1), .rise_max(rmax1), .fall_min(fmin1), .fall_max(fmax1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int expv);
      n_vec++;
      if (got != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   task automatic push(input int dut, input int kind, input logic rise, input int delay, input int at);
      ev_t e;
      e.kind  = kind;
      e.rise  = rise;
      e.delay = W'(delay);
      e.at    = at;
      if (dut == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic pulse(input int dut, input int kind, input logic rise, input logic [W-1:0] delay);
      ev_t e;
      n_vec++;
      if ((dut == 0 && q0.size() == 0) || (dut == 1 && q1.size() == 0)) begin
         n_err++;
         $display("FAIL dut%0d unexpected pulse: kind %0d rise %0d delay %0d at cycle %0d, expected none",
                  dut, kind, rise, delay, cyc);
         return;
      end
      if (dut == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == 0 && (e.rise != rise || e.delay != delay))) begin
         n_err++;
         $display("FAIL dut%0d pulse: got kind %0d rise %0d delay %0d cycle %0d, expected kind %0d rise %0d delay %0d cycle %0d",
                  dut, kind, rise, delay, cyc, e.kind, e.rise, e.delay, e.at);
      end
   endtask

   // Monitor: every pulse on either DUT must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (v0) pulse(0, 0, r0, d0);
         if (t0) pulse(0, 1, 1'b0, '0);
         if (a0) pulse(0, 2, 1'b0, '0);
         if (v1) pulse(1, 0, r1, d1);
         if (t1) pulse(1, 1, 1'b0, '0);
         if (a1) pulse(1, 2, 1'b0, '0);
      end
   end

   // Non-inverting path: stim to level s, resp follows d cycles later.
   task automatic step0(input logic s, input int d);
      stim0 = s;
      push(0, 0, s, d, cyc + 1 + d);
      repeat (d) tick();
      resp0 = s;
      tick();
   endtask

   // Inverting path: resp goes to ~s; the measured direction is the resp direction.
   task automatic step1(input logic s, input int d);
      stim1 = s;
      push(1, 0, ~s, d, cyc + 1 + d);
      repeat (d) tick();
      resp1 = ~s;
      tick();
   endtask

   task automatic chk_stats0(input string tag, input int rmn, input int rmx, input int fmn, input int fmx);
      chk({tag, " rise_min"}, rmin0, rmn);
      chk({tag, " rise_max"}, rmax0, rmx);
      chk({tag, " fall_min"}, fmin0, fmn);
      chk({tag, " fall_max"}, fmax0, fmx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      stim0 = 1'b1; resp0 = 1'b1;
      stim1 = 1'b1; resp1 = 1'b0;
      repeat (3) tick();
      chk("reset meas_valid", v0, 0);
      chk("reset timeout", t0, 0);
      chk("reset abort", a0, 0);
      chk("reset meas_rise", r0, 0);
      chk("reset meas_delay", d0, 0);
      chk_stats0("reset", 255, 0, 255, 0);
      chk("reset dut1 rise_min", rmin1, 255);
      rst_n = 1'b1;
      repeat (5) tick();

      // zero-delay fall, then clear the statistics it produced
      step0(1'b0, 0);
      chk("zero fall_max", fmax0, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_stats0("after clear", 255, 0, 255, 0);

      step0(1'b1, 3);
      chk("rise3 meas_delay", d0, 3);
      chk_stats0("rise3", 3, 3, 255, 0);

      step0(1'b0, 2);
      chk_stats0("fall2", 3, 3, 2, 2);

      // resp held low after stim rise: timeout, stats untouched
      stim0 = 1'b1;
      push(0, 1, 1'b0, 0, cyc + 1 + TO);
      repeat (TO + 1) tick();
      chk_stats0("timeout", 3, 3, 2, 2);
      resp0 = 1'b1;
      repeat (3) tick();

      step0(1'b0, 5);
      chk_stats0("fall5", 3, 3, 2, 5);

      // two aborts in a row, then timeout from the last edge
      stim0 = 1'b1;
      repeat (2) tick();
      stim0 = 1'b0;
      push(0, 2, 1'b0, 0, cyc + 1);
      tick();
      stim0 = 1'b1;
      push(0, 2, 1'b0, 0, cyc + 1);
      push(0, 1, 1'b0, 0, cyc + 1 + TO);
      repeat (TO + 1) tick();
      chk_stats0("abort", 3, 3, 2, 5);

      // clear mid-WAIT: no pulses afterwards, stats emptied
      resp0 = 1'b1;
      repeat (2) tick();
      stim0 = 1'b0;
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_stats0("clear mid-wait", 255, 0, 255, 0);
      repeat (TO + 5) tick();
      resp0 = 1'b0;
      repeat (3) tick();

      // inverting path
      step1(1'b0, 0);
      step1(1'b1, 4);
      chk("inv meas_rise", r1, 0);
      chk("inv meas_delay", d1, 4);
      chk("inv fall_min", fmin1, 4);
      chk("inv fall_max", fmax1, 4);
      chk("inv rise_max", rmax1, 0);

      repeat (5) tick();
      chk("dut0 pending pulses", q0.size(), 0);
      chk("dut1 pending pulses", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
